// File: rtl/feu_pkg.sv
// Shared constants for the feu_ctrl traffic-light controller: state codes,
// lamp patterns, default phase durations and the duration clamp helper.
package feu_pkg;

    typedef enum logic [2:0] {
        ST_A_GRN = 3'd0,
        ST_A_YEL = 3'd1,
        ST_RED1  = 3'd2,
        ST_B_GRN = 3'd3,
        ST_B_YEL = 3'd4,
        ST_RED2  = 3'd5,
        ST_NIGHT = 3'd6,
        ST_BAD   = 3'd7
    } feu_state_e;

    // Lamp order: {A_R, A_Y, A_G, B_R, B_Y, B_G}
    localparam logic [5:0] LAMP_A_GRN   = 6'b001100;
    localparam logic [5:0] LAMP_A_YEL   = 6'b010100;
    localparam logic [5:0] LAMP_ALL_RED = 6'b100100;
    localparam logic [5:0] LAMP_B_GRN   = 6'b100001;
    localparam logic [5:0] LAMP_B_YEL   = 6'b100010;
    localparam logic [5:0] LAMP_NIGHT   = 6'b010010;

    localparam int DEF_TW        = 5;
    localparam int DEF_GREEN_A   = 15;
    localparam int DEF_GREEN_B   = 10;
    localparam int DEF_YELLOW    = 3;
    localparam int DEF_ALLRED    = 1;
    localparam int DEF_PED_MIN   = 5;

    // A zero duration would never reach timer==1, so it is promoted to one tick.
    function automatic int clamp_dur(input int d, input int tw);
        int max_v;
        max_v = (1 << tw) - 1;
        if (d <= 0)
            return 1;
        else if (d > max_v)
            return max_v;
        else
            return d;
    endfunction

endpackage

// File: rtl/feu_phase_timer.sv
// Loadable down-counter used as the phase timer; load has priority over
// decrement and the count never wraps below zero.
module feu_phase_timer #(
    parameter int             TW      = 5,
    parameter logic [TW-1:0]  RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          dec,
    output logic [TW-1:0] count,
    output logic          at_one
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec && (count_q != '0))
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= RST_VAL;
        else
            count_q <= count_d;
    end

    assign count  = count_q;
    assign at_one = (count_q == TW'(1));

endmodule

// File: rtl/feu_ctrl.sv
// Two-road traffic-light controller with all-red clearance and night flashing.
// Define FEU_PED_EN to build the pedestrian latch, green shortening and walk lamp.
module feu_ctrl
    import feu_pkg::*;
#(
    parameter int TW        = DEF_TW,
    parameter int T_GREEN_A = DEF_GREEN_A,
    parameter int T_GREEN_B = DEF_GREEN_B,
    parameter int T_YELLOW  = DEF_YELLOW,
    parameter int T_ALLRED  = DEF_ALLRED,
    parameter int T_PED_MIN = DEF_PED_MIN
) (
    input  logic          clk1h,
    input  logic          rst_n,
    input  logic          night,
    input  logic          ped_req,
    output logic [5:0]    out,
    output logic [2:0]    phase,
    output logic [TW-1:0] remain,
    output logic          ped_walk
);

    localparam logic [TW-1:0] DUR_GA = TW'(clamp_dur(T_GREEN_A, TW));
    localparam logic [TW-1:0] DUR_GB = TW'(clamp_dur(T_GREEN_B, TW));
    localparam logic [TW-1:0] DUR_Y  = TW'(clamp_dur(T_YELLOW, TW));
    localparam logic [TW-1:0] DUR_AR = TW'(clamp_dur(T_ALLRED, TW));
    localparam logic [TW-1:0] DUR_PM = TW'(clamp_dur(T_PED_MIN, TW));

    feu_state_e    state_q, state_d;
    logic [5:0]    out_q, out_d;
    logic          t_load, t_dec, t_at_one;
    logic [TW-1:0] t_val, t_count;
    logic          ped_pend;

    feu_phase_timer #(.TW(TW), .RST_VAL(DUR_GA)) u_timer (
        .clk      (clk1h),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .count    (t_count),
        .at_one   (t_at_one)
    );

    always_comb begin
        state_d = state_q;
        t_load  = 1'b0;
        t_val   = '0;
        t_dec   = 1'b0;
        case (state_q)
            ST_A_GRN: begin
                if (t_at_one) begin
                    state_d = ST_A_YEL; t_load = 1'b1; t_val = DUR_Y;
                end else if (ped_pend && (t_count > DUR_PM)) begin
                    // Once loaded the timer is <= DUR_PM, so this fires once per green.
                    t_load = 1'b1; t_val = DUR_PM;
                end else begin
                    t_dec = 1'b1;
                end
            end
            ST_A_YEL: begin
                if (t_at_one) begin
                    state_d = ST_RED1; t_load = 1'b1; t_val = DUR_AR;
                end else t_dec = 1'b1;
            end
            ST_RED1: begin
                if (t_at_one) begin
                    state_d = night ? ST_NIGHT : ST_B_GRN;
                    t_load  = 1'b1;
                    t_val   = night ? '0 : DUR_GB;
                end else t_dec = 1'b1;
            end
            ST_B_GRN: begin
                if (t_at_one) begin
                    state_d = ST_B_YEL; t_load = 1'b1; t_val = DUR_Y;
                end else t_dec = 1'b1;
            end
            ST_B_YEL: begin
                if (t_at_one) begin
                    state_d = ST_RED2; t_load = 1'b1; t_val = DUR_AR;
                end else t_dec = 1'b1;
            end
            ST_RED2: begin
                if (t_at_one) begin
                    state_d = night ? ST_NIGHT : ST_A_GRN;
                    t_load  = 1'b1;
                    t_val   = night ? '0 : DUR_GA;
                end else t_dec = 1'b1;
            end
            ST_NIGHT: begin
                t_load = 1'b1;
                if (!night) begin
                    state_d = ST_RED1; t_val = DUR_AR;
                end
            end
            default: begin
                state_d = ST_RED1; t_load = 1'b1; t_val = DUR_AR;
            end
        endcase
    end

    always_comb begin
        out_d = LAMP_ALL_RED;
        case (state_d)
            ST_A_GRN: out_d = LAMP_A_GRN;
            ST_A_YEL: out_d = LAMP_A_YEL;
            ST_B_GRN: out_d = LAMP_B_GRN;
            ST_B_YEL: out_d = LAMP_B_YEL;
            ST_NIGHT: out_d = ((state_q == ST_NIGHT) && (out_q == LAMP_NIGHT)) ? 6'b000000 : LAMP_NIGHT;
            default:  out_d = LAMP_ALL_RED;
        endcase
    end

    always_ff @(posedge clk1h or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_A_GRN;
            out_q   <= LAMP_A_GRN;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

`ifdef FEU_PED_EN
    logic ped_q, ped_d, walk_q, walk_d;

    // A request on the same tick counts as pending, so shortening starts next tick.
    assign ped_pend = ped_q | ped_req;

    always_comb begin
        ped_d  = ped_q;
        walk_d = 1'b0;
        if ((state_q != ST_B_GRN) && ped_req)
            ped_d = 1'b1;
        if (state_d == ST_B_GRN) begin
            if (state_q == ST_B_GRN) begin
                walk_d = walk_q;
            end else begin
                walk_d = ped_pend;
                ped_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk1h or negedge rst_n) begin
        if (!rst_n) begin
            ped_q  <= 1'b0;
            walk_q <= 1'b0;
        end else begin
            ped_q  <= ped_d;
            walk_q <= walk_d;
        end
    end

    assign ped_walk = walk_q;
`else
    logic unused_ped;
    assign unused_ped = ped_req;
    assign ped_pend   = 1'b0;
    assign ped_walk   = 1'b0;
`endif

    assign out    = out_q;
    assign phase  = state_q;
    assign remain = t_count;

endmodule
